// File: rtl/dither_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dither_gen_pkg : LFSR taps, default seed table and FSM state type shared    |
// |                  by the dither generator.                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dither_gen_pkg;

  // Tap bit positions (0-based) for taps 32, 22, 2, 1
  localparam int C_TAP_32 = 31;
  localparam int C_TAP_22 = 21;
  localparam int C_TAP_2  = 1;
  localparam int C_TAP_1  = 0;

  // The XNOR LFSR never leaves the all-ones state
  localparam logic [31:0] C_LOCKUP = 32'hFFFF_FFFF;

  localparam logic [31:0] C_DEFAULT_SEEDS [0:7] = '{
    32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, 32'hA5A5_0001,
    32'h5A5A_1234, 32'hDEAD_BEEF, 32'hC0FF_EE00, 32'h1357_9BDF
  };

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } dg_state_t;

  // Which sources contribute for a given mode
  function automatic logic [7:0] src_mask(input logic [1:0] mode, input int n_src);
    logic [7:0] m;
    m = 8'h00;
    case (mode)
      2'b01:   m = 8'h01;
      2'b10:   m = 8'h03;
      2'b11:   m = 8'(8'hFF >> (8 - n_src));
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dither_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dither_gen_if : control, reseed handshake and sample output of dither_gen.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface dither_gen_if #(
  parameter int OUT_W = 24
);
  logic                    en_i;
  logic [1:0]              mode_i;
  logic [4:0]              shift_i;
  logic                    seed_valid_i;
  logic [31:0]             seed_i;
  logic                    seed_ready_o;
  logic signed [OUT_W-1:0] dith_o;
  logic                    dith_valid_o;

  modport master (
    output en_i, mode_i, shift_i, seed_valid_i, seed_i,
    input  seed_ready_o, dith_o, dith_valid_o
  );

  modport slave (
    input  en_i, mode_i, shift_i, seed_valid_i, seed_i,
    output seed_ready_o, dith_o, dith_valid_o
  );
endinterface
`default_nettype wire

// File: rtl/dither_lfsr32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dither_lfsr32 : one 32-bit Fibonacci XNOR LFSR noise source with load,      |
// |                 advance and hold; lock-up seeds fall back to the default.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dither_lfsr32
  import dither_gen_pkg::*;
#(
  parameter logic [31:0] DEFAULT_SEED = 32'h0000_0001
) (
  input  wire logic        clock,
  input  wire logic        reset,
  input  wire logic        i_load,
  input  wire logic [31:0] i_seed,
  input  wire logic        i_advance,
  output logic [31:0]      o_state
);

  logic [31:0] r_state;
  logic        w_feedback;

  assign w_feedback = ~(r_state[C_TAP_32] ^ r_state[C_TAP_22] ^
                        r_state[C_TAP_2]  ^ r_state[C_TAP_1]);

  // Load wins over advance so a reseed is never lost to a concurrent sample
  always_ff @(posedge clock) begin
    if (reset)
      r_state <= DEFAULT_SEED;
    else if (i_load)
      r_state <= (i_seed == C_LOCKUP) ? DEFAULT_SEED : i_seed;
    else if (i_advance)
      r_state <= {r_state[30:0], w_feedback};
  end

  assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/dither_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dither_gen : N_SRC summed LFSR sources giving off / rectangular /           |
// |              triangular / near-Gaussian dither with shift attenuation.     |
// |              Define DITHER_HPF_EN for first-difference (high-pass) output. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dither_gen
  import dither_gen_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int SRC_W = 16,
  parameter int OUT_W = 24
) (
  input wire logic     clock,
  input wire logic     reset,
  dither_gen_if.slave  bus
);

  localparam int SUM_W = SRC_W + 3;

  dg_state_t r_state, w_state_nxt;
  logic [2:0]               r_beat, w_beat_nxt;
  logic                     w_seed_acc;
  logic                     w_sample;
  logic [N_SRC-1:0]         w_load;
  logic [31:0]              w_src [N_SRC];
  logic [7:0]               w_mask;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  w_f;
  logic signed [OUT_W-1:0]  w_dith_nxt;
  logic signed [OUT_W-1:0]  r_dith;
  logic                     r_dith_valid;

  assign bus.seed_ready_o = (r_state != ST_FLUSH);
  assign w_seed_acc       = bus.seed_valid_i & bus.seed_ready_o;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_beat  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_load      = '0;
    w_sample    = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_sample = bus.en_i;
        if (w_seed_acc) begin
          w_load[0]   = 1'b1;
          w_beat_nxt  = 3'd1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_seed_acc) begin
          for (int k = 0; k < N_SRC; k++)
            if (r_beat == 3'(k)) w_load[k] = 1'b1;
          if (r_beat == 3'(N_SRC - 1)) begin
            w_beat_nxt  = 3'd0;
            w_state_nxt = ST_FLUSH;
          end else begin
            w_beat_nxt  = r_beat + 3'd1;
          end
        end
      end
      ST_FLUSH: begin
        w_beat_nxt  = 3'd0;
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_beat_nxt  = 3'd0;
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    dither_lfsr32 #(
      .DEFAULT_SEED (C_DEFAULT_SEEDS[k])
    ) u_lfsr (
      .clock     (clock),
      .reset     (reset),
      .i_load    (w_load[k]),
      .i_seed    (bus.seed_i),
      .i_advance (w_sample),
      .o_state   (w_src[k])
    );
  end

  // Three guard bits cover up to eight full-scale sources
  assign w_mask = src_mask(bus.mode_i, N_SRC);

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N_SRC; k++)
      if (w_mask[k])
        w_sum = w_sum + {{3{w_src[k][SRC_W-1]}}, w_src[k][SRC_W-1:0]};
  end

  assign w_f = w_sum >>> bus.shift_i;

`ifdef DITHER_HPF_EN
  logic signed [SUM_W-1:0] r_f_prev;
  logic signed [OUT_W:0]   w_diff;

  always_ff @(posedge clock) begin
    if (reset || r_state == ST_FLUSH)
      r_f_prev <= '0;
    else if (w_sample)
      r_f_prev <= w_f;
  end

  assign w_diff = {{(OUT_W + 1 - SUM_W){w_f[SUM_W-1]}}, w_f}
                - {{(OUT_W + 1 - SUM_W){r_f_prev[SUM_W-1]}}, r_f_prev};

  always_comb begin
    w_dith_nxt = w_diff[OUT_W-1:0];
    if (w_diff[OUT_W] != w_diff[OUT_W-1])
      w_dith_nxt = w_diff[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end
`else
  assign w_dith_nxt = {{(OUT_W - SUM_W){w_f[SUM_W-1]}}, w_f};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dith       <= '0;
      r_dith_valid <= 1'b0;
    end else begin
      r_dith_valid <= w_sample;
      if (w_sample) r_dith <= w_dith_nxt;
    end
  end

  assign bus.dith_o       = r_dith;
  assign bus.dith_valid_o = r_dith_valid;

  // Upper source bits only matter for the LFSR sequence itself
  logic w_unused_hi;
  always_comb begin
    w_unused_hi = 1'b0;
    for (int k = 0; k < N_SRC; k++)
      w_unused_hi = w_unused_hi ^ (^w_src[k][31:SRC_W]);
  end

endmodule
`default_nettype wire
